// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data load/store.
// Data has priority, but a waiting fetch is forced through after STARVE_LIMIT data grants.
module mem_port_arbiter #(
  parameter int STARVE_LIMIT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ready,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_wstrb,
  output logic [31:0] d_rdata,
  output logic        d_ready,
  output logic        m_req,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wstrb,
  input  logic        m_gnt,
  input  logic        m_rvalid,
  input  logic [31:0] m_rdata,
  output logic        stall_if,
  output logic        stall_mem
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);
  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_D  = 1'b1;

  state_t            state_q, state_d;
  logic              owner_q, owner_d;
  logic [CNT_W-1:0]  starve_cnt_q, starve_cnt_d;
  logic              m_req_q, m_req_d;
  logic              m_we_q, m_we_d;
  logic [31:0]       m_addr_q, m_addr_d;
  logic [31:0]       m_wdata_q, m_wdata_d;
  logic [3:0]        m_wstrb_q, m_wstrb_d;
  logic [31:0]       if_rdata_q, if_rdata_d;
  logic [31:0]       d_rdata_q, d_rdata_d;
  logic              if_ready_q, if_ready_d;
  logic              d_ready_q, d_ready_d;
  logic              pick_fetch;
  logic              grant_ok;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    starve_cnt_d = starve_cnt_q;
    m_req_d      = m_req_q;
    m_we_d       = m_we_q;
    m_addr_d     = m_addr_q;
    m_wdata_d    = m_wdata_q;
    m_wstrb_d    = m_wstrb_q;
    if_rdata_d   = if_rdata_q;
    d_rdata_d    = d_rdata_q;
    if_ready_d   = 1'b0;
    d_ready_d    = 1'b0;
    pick_fetch   = 1'b0;
    // Requesters still see their ready pulse this cycle and have not yet
    // dropped the completed request, so nothing is granted until it clears.
    grant_ok     = !if_ready_q && !d_ready_q;

    unique case (state_q)
      IDLE: begin
        if (grant_ok && (if_req || d_req)) begin
          pick_fetch = if_req && (!d_req || (starve_cnt_q == CNT_MAX));
          m_req_d    = 1'b1;
          state_d    = ISSUE;
          if (pick_fetch) begin
            owner_d      = OWN_IF;
            m_we_d       = 1'b0;
            m_addr_d     = if_addr;
            m_wdata_d    = 32'h0;
            m_wstrb_d    = 4'h0;
            starve_cnt_d = '0;
          end else begin
            owner_d   = OWN_D;
            m_we_d    = d_we;
            m_addr_d  = d_addr;
            m_wdata_d = d_wdata;
            m_wstrb_d = d_wstrb;
            if (if_req && (starve_cnt_q != CNT_MAX)) begin
              starve_cnt_d = starve_cnt_q + 1'b1;
            end
          end
        end
      end
      ISSUE: begin
        // A response in the grant cycle is not accepted; only WAIT captures.
        if (m_gnt) begin
          m_req_d = 1'b0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (m_rvalid) begin
          state_d = RESP;
          if (owner_q == OWN_IF) begin
            if_rdata_d = m_rdata;
          end else if (!m_we_q) begin
            d_rdata_d = m_rdata;
          end
        end
      end
      RESP: begin
        if (owner_q == OWN_IF) begin
          if_ready_d = 1'b1;
        end else begin
          d_ready_d = 1'b1;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_q      <= OWN_IF;
      starve_cnt_q <= '0;
      m_req_q      <= 1'b0;
      m_we_q       <= 1'b0;
      m_addr_q     <= 32'h0;
      m_wdata_q    <= 32'h0;
      m_wstrb_q    <= 4'h0;
      if_rdata_q   <= 32'h0;
      d_rdata_q    <= 32'h0;
      if_ready_q   <= 1'b0;
      d_ready_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      starve_cnt_q <= starve_cnt_d;
      m_req_q      <= m_req_d;
      m_we_q       <= m_we_d;
      m_addr_q     <= m_addr_d;
      m_wdata_q    <= m_wdata_d;
      m_wstrb_q    <= m_wstrb_d;
      if_rdata_q   <= if_rdata_d;
      d_rdata_q    <= d_rdata_d;
      if_ready_q   <= if_ready_d;
      d_ready_q    <= d_ready_d;
    end
  end

  assign m_req     = m_req_q;
  assign m_we      = m_we_q;
  assign m_addr    = m_addr_q;
  assign m_wdata   = m_wdata_q;
  assign m_wstrb   = m_wstrb_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign if_ready  = if_ready_q;
  assign d_ready   = d_ready_q;
  assign stall_if  = if_req & ~if_ready_q;
  assign stall_mem = d_req & ~d_ready_q;

endmodule
